// File: rtl/hamming_rx_decoder.sv
// Serial Hamming frame receiver: folds each accepted bit into a running syndrome/parity and registers the corrected 11-bit payload.
// Build option HAMMING_SECDED_EN: 16-bit SECDED frames (positions 0..15); undefined gives 15-bit SEC frames (positions 1..15).
module hamming_rx_decoder #(
    parameter bit ERR_STICKY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sof,
    input  logic        clr_err,
    output logic [10:0] dout,
    output logic        dout_valid,
    output logic        err_single,
    output logic        err_double,
    output logic [3:0]  err_pos,
    output logic        busy
);

`ifdef HAMMING_SECDED_EN
    localparam bit         SECDED    = 1'b1;
    localparam logic [3:0] FIRST_POS = 4'd0;
`else
    localparam bit         SECDED    = 1'b0;
    localparam logic [3:0] FIRST_POS = 4'd1;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic [3:0]  syn_q;
    logic        par_q;
    logic [9:0]  data_q;   // payload bits 0..9; bit 10 (pos 15) only ever arrives on the final edge
    logic [10:0] dout_q;
    logic        dout_valid_q;
    logic        err_single_q;
    logic        err_double_q;
    logic [3:0]  err_pos_q;

    logic [3:0]  syn_fin;
    logic        par_fin;
    logic        new_single;
    logic        new_double;
    logic [3:0]  new_pos;
    logic [10:0] raw_payload;
    logic [10:0] fix_payload;

    // Data positions are the non-zero, non-power-of-two positions.
    function automatic logic is_data(input logic [3:0] p);
        return (p != 4'd0) && ((p & (p - 4'd1)) != 4'd0);
    endfunction

    function automatic logic [3:0] data_idx(input logic [3:0] p);
        logic [3:0] idx;
        if (p == 4'd3)
            idx = 4'd0;
        else if (p < 4'd8)
            idx = p - 4'd4;
        else
            idx = p - 4'd5;
        return idx;
    endfunction

    // Final decode folds in the position-15 bit presented on the completing edge.
    always_comb begin
        syn_fin     = syn_q ^ (din ? 4'd15 : 4'd0);
        par_fin     = par_q ^ din;
        new_single  = SECDED ? par_fin : (syn_fin != 4'd0);
        new_double  = SECDED && !par_fin && (syn_fin != 4'd0);
        new_pos     = new_single ? syn_fin : 4'd0;
        raw_payload = {din, data_q};
        fix_payload = raw_payload;
        if (new_single && is_data(syn_fin))
            fix_payload[data_idx(syn_fin)] = ~raw_payload[data_idx(syn_fin)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            syn_q        <= 4'd0;
            par_q        <= 1'b0;
            data_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_pos_q    <= 4'd0;
        end else begin
            dout_valid_q <= 1'b0;
            if (ERR_STICKY && clr_err) begin
                err_single_q <= 1'b0;
                err_double_q <= 1'b0;
            end
            if (din_valid) begin
                if (state_q == IDLE || sof) begin
                    // Start (or restart) a frame; any partial frame is dropped silently.
                    state_q <= RECV;
                    count_q <= FIRST_POS + 4'd1;
                    syn_q   <= din ? FIRST_POS : 4'd0;
                    par_q   <= din;
                    data_q  <= '0;
                end else if (count_q == 4'd15) begin
                    state_q      <= IDLE;
                    count_q      <= 4'd0;
                    syn_q        <= 4'd0;
                    par_q        <= 1'b0;
                    data_q       <= '0;
                    dout_q       <= fix_payload;
                    err_pos_q    <= new_pos;
                    dout_valid_q <= 1'b1;
                    if (ERR_STICKY) begin
                        // A completing frame's flags override a simultaneous clear.
                        err_single_q <= (err_single_q && !clr_err) || new_single;
                        err_double_q <= (err_double_q && !clr_err) || new_double;
                    end else begin
                        err_single_q <= new_single;
                        err_double_q <= new_double;
                    end
                end else begin
                    count_q <= count_q + 4'd1;
                    syn_q   <= syn_q ^ (din ? count_q : 4'd0);
                    par_q   <= par_q ^ din;
                    if (is_data(count_q))
                        data_q[data_idx(count_q)] <= din;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err_single = err_single_q;
    assign err_double = err_double_q;
    assign err_pos    = err_pos_q;
    assign busy       = (state_q == RECV);

endmodule
